// File: rtl/led_matrix_ctrl.sv
// led_matrix_ctrl: UART byte-stream parser, frame store, brightness control and PWM row scan.
// Define DOUBLE_BUFFER_EN to load frames into a back buffer that swaps in at the end of a scan.
module led_matrix_ctrl #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int BRIGHT_W    = 8,
  parameter int BRIGHT_INIT = 128,
  parameter int STEP        = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                key_up,
  input  logic                key_down,
  output logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col,
  output logic [BRIGHT_W-1:0] brightness,
  output logic                frame_done,
  output logic                proto_err,
  output logic                busy
);
  localparam int LANES  = COLS / 8;
  localparam int NBYTES = ROWS * LANES;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BRIGHT_W-1:0] PWM_MAX = '1;
  localparam logic [BRIGHT_W:0]   STEP_X  = (BRIGHT_W + 1)'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_BRIGHT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    byte_cnt;
  logic [TO_W-1:0]     idle_cnt;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [BRIGHT_W-1:0] bright_l;
  logic [BRIGHT_W-1:0] bright_eff;
  logic [RIDX_W-1:0]   row_idx;
  logic [RIDX_W-1:0]   wr_row;
  logic [LANE_W-1:0]   wr_lane;
  logic [COLS-1:0]     row_data;
  logic [BRIGHT_W:0]   up_sum;
  logic                wr_en;
  logic                frame_last;
  logic                cmd_bright;

  assign wr_en      = (state == S_FRAME) && in_valid;
  assign frame_last = wr_en && (byte_cnt == CNT_W'(NBYTES - 1));
  assign cmd_bright = (state == S_BRIGHT) && in_valid;
  assign wr_row     = RIDX_W'(int'(byte_cnt) / LANES);
  assign wr_lane    = LANE_W'(int'(byte_cnt) % LANES);
  assign busy       = (state != S_IDLE);
  assign up_sum     = {1'b0, brightness} + STEP_X;
  // The first cycle of a slot already uses the value being latched for the rest of it.
  assign bright_eff = (pwm_cnt == '0) ? brightness : bright_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      if (in_valid || state == S_IDLE) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + TO_W'(1);
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_data == 8'hA5) begin
            state    <= S_FRAME;
            byte_cnt <= '0;
          end else if (in_valid && in_data == 8'hB1) begin
            state <= S_BRIGHT;
          end
        end
        S_FRAME: begin
          if (in_valid) byte_cnt <= byte_cnt + CNT_W'(1);
          if (frame_last) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
          end
        end
        S_BRIGHT: if (in_valid) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (state != S_IDLE && !in_valid && idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state     <= S_IDLE;
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brightness <= BRIGHT_W'(BRIGHT_INIT);
    end else if (cmd_bright) begin
      brightness <= in_data[7 -: BRIGHT_W];
    end else if (key_up && !key_down) begin
      brightness <= up_sum[BRIGHT_W] ? PWM_MAX : up_sum[BRIGHT_W-1:0];
    end else if (key_down && !key_up) begin
      brightness <= ({1'b0, brightness} < STEP_X) ? '0 : brightness - STEP_X[BRIGHT_W-1:0];
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic [COLS-1:0] mem_a [ROWS];
  logic [COLS-1:0] mem_b [ROWS];
  logic            disp_sel;
  logic            swap_pend;
  logic            scan_wrap;

  assign scan_wrap = (pwm_cnt == PWM_MAX) && (row_idx == RIDX_W'(ROWS - 1));
  assign row_data  = disp_sel ? mem_b[row_idx] : mem_a[row_idx];

  // Frames land in whichever buffer is hidden; the swap waits for the scan to leave the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_a[r] <= '0;
        mem_b[r] <= '0;
      end
      disp_sel  <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (wr_en && disp_sel)  mem_a[wr_row][8*int'(wr_lane) +: 8] <= in_data;
      if (wr_en && !disp_sel) mem_b[wr_row][8*int'(wr_lane) +: 8] <= in_data;
      if (scan_wrap && swap_pend) disp_sel <= ~disp_sel;
      if (frame_last)     swap_pend <= 1'b1;
      else if (scan_wrap) swap_pend <= 1'b0;
    end
  end
`else
  logic [COLS-1:0] mem [ROWS];

  assign row_data = mem[row_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    end else if (wr_en) begin
      mem[wr_row][8*int'(wr_lane) +: 8] <= in_data;
    end
  end
`endif

  // Last count of each slot is blanking so row changes never ghost into the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      row_idx  <= '0;
      bright_l <= BRIGHT_W'(BRIGHT_INIT);
      row      <= '0;
      col      <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      if (pwm_cnt == PWM_MAX)
        row_idx <= (row_idx == RIDX_W'(ROWS - 1)) ? '0 : row_idx + RIDX_W'(1);
      if (pwm_cnt == '0) bright_l <= brightness;
      if (pwm_cnt == PWM_MAX) begin
        row <= '0;
        col <= '0;
      end else begin
        row <= ROWS'(1) << row_idx;
        col <= (pwm_cnt < bright_eff) ? row_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_ctrl.sv
// Testbench for led_matrix_ctrl: cycle-level reference model of the scan/parser plus directed checks.
// Builds with or without DOUBLE_BUFFER_EN, matching the design.
module tb_led_matrix_ctrl;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int BW     = 8;
  localparam int TO     = 300;
  localparam int SLOT   = 256;
  localparam int SCAN   = SLOT * ROWS;
  localparam int NBYTES = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            key_up = 1'b0;
  logic            key_down = 1'b0;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [BW-1:0]   brightness;
  logic            frame_done;
  logic            proto_err;
  logic            busy;

  int nvec = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  int         t, mbright, slot_bright, mstate, bcount, idle_edges, m_pwm, m_ridx;
  bit         m_cmd;
  logic [7:0] img [ROWS];
`ifdef DOUBLE_BUFFER_EN
  logic [7:0] back [ROWS];
  logic [7:0] tmp;
  bit         pend, m_swap;
`endif
  logic [7:0] exp_row, exp_col;
  int         exp_bright;
  bit         exp_fd, exp_pe, exp_busy;

  logic [7:0] f1 [NBYTES];
  logic [7:0] f2 [NBYTES];
  int         cnt_on, cnt_row, got;

  led_matrix_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .BRIGHT_W(BW), .BRIGHT_INIT(128), .STEP(16), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .key_up(key_up), .key_down(key_down), .row(row), .col(col),
    .brightness(brightness), .frame_done(frame_done), .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit v, input bit up, input bit dn);
    @(negedge clk);
    in_data = b; in_valid = v; key_up = up; key_down = dn;
    @(negedge clk);
    in_valid = 1'b0; key_up = 1'b0; key_down = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
  endtask

  // Reference model: t counts clock edges since reset, so slot, row and duty come from plain arithmetic.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      t = 0; mbright = 128; slot_bright = 128; mstate = 0; bcount = 0; idle_edges = 0;
      for (int r = 0; r < ROWS; r++) img[r] = 8'h00;
`ifdef DOUBLE_BUFFER_EN
      for (int r = 0; r < ROWS; r++) back[r] = 8'h00;
      pend = 1'b0;
`endif
      exp_row = 8'h00; exp_col = 8'h00; exp_bright = 128;
      exp_fd = 1'b0; exp_pe = 1'b0; exp_busy = 1'b0;
    end else begin
      m_pwm  = t % SLOT;
      m_ridx = (t / SLOT) % ROWS;
      if (m_pwm == 0) slot_bright = mbright;
      if (m_pwm == SLOT - 1) begin
        exp_row = 8'h00; exp_col = 8'h00;
      end else begin
        exp_row = 8'(1 << m_ridx);
        exp_col = (m_pwm < slot_bright) ? img[m_ridx] : 8'h00;
      end
`ifdef DOUBLE_BUFFER_EN
      m_swap = pend && ((t % SCAN) == SCAN - 1);
`endif
      m_cmd = 1'b0; exp_fd = 1'b0; exp_pe = 1'b0;
      if (in_valid) begin
        idle_edges = 0;
        case (mstate)
          0: begin
            if (in_data == 8'hA5) begin mstate = 1; bcount = 0; end
            else if (in_data == 8'hB1) mstate = 2;
          end
          1: begin
`ifdef DOUBLE_BUFFER_EN
            back[bcount] = in_data;
`else
            img[bcount] = in_data;
`endif
            bcount++;
            if (bcount == NBYTES) begin mstate = 0; exp_fd = 1'b1; end
          end
          default: begin mbright = int'(in_data); mstate = 0; m_cmd = 1'b1; end
        endcase
      end else if (mstate != 0) begin
        idle_edges++;
        if (idle_edges == TO) begin mstate = 0; exp_pe = 1'b1; idle_edges = 0; end
      end
      if (!m_cmd && key_up && !key_down)      mbright = (mbright + 16 > 255) ? 255 : mbright + 16;
      else if (!m_cmd && key_down && !key_up) mbright = (mbright < 16) ? 0 : mbright - 16;
`ifdef DOUBLE_BUFFER_EN
      if (m_swap) begin
        for (int r = 0; r < ROWS; r++) begin tmp = img[r]; img[r] = back[r]; back[r] = tmp; end
      end
      if (exp_fd) pend = 1'b1;
      else if ((t % SCAN) == SCAN - 1) pend = 1'b0;
`endif
      exp_busy = (mstate != 0);
      exp_bright = mbright;
      t++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      checkOutput("row", 32'(row), 32'(exp_row));
      checkOutput("col", 32'(col), 32'(exp_col));
      checkOutput("brightness", 32'(brightness), 32'(exp_bright));
      checkOutput("frame_done", 32'(frame_done), 32'(exp_fd));
      checkOutput("proto_err", 32'(proto_err), 32'(exp_pe));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
    end
  end

  initial begin
    #2000000;
    nfail++;
    $display("[TB] FAIL watchdog at %0t: got still running, expected finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    f1 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    f2 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_brightness", 32'(brightness), 32'd128);
    checkOutput("rst_row", 32'(row), 32'h0);
    checkOutput("rst_col", 32'(col), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_row", 32'(row), 32'h01);

    // Frame load and row 0 duty at brightness 128
    sendByte(8'hA5);
    checkOutput("busy_in_frame", 32'(busy), 32'h1);
    foreach (f1[i]) sendByte(f1[i]);
    checkOutput("frame_done_pulse", 32'(frame_done), 32'h1);
    @(negedge clk);
    checkOutput("frame_done_width", 32'(frame_done), 32'h0);
`ifdef DOUBLE_BUFFER_EN
    repeat (SCAN) @(negedge clk);
`endif
    cnt_on = 0; cnt_row = 0;
    repeat (SCAN) begin
      @(negedge clk);
      if (row == 8'h01) cnt_row++;
      if (row == 8'h01 && col == 8'h81) cnt_on++;
    end
    checkOutput("row0_slot_cycles", 32'(cnt_row), 32'd255);
    checkOutput("row0_on_cycles", 32'(cnt_on), 32'd128);

    // Brightness commands: dark and full
    sendByte(8'hB1); sendByte(8'h00);
    checkOutput("cmd_bright_0", 32'(brightness), 32'd0);
    repeat (SLOT) @(negedge clk);
    cnt_on = 0;
    repeat (SCAN) begin @(negedge clk); if (col != 8'h00) cnt_on++; end
    checkOutput("dark_col_cycles", 32'(cnt_on), 32'd0);
    sendByte(8'hB1); sendByte(8'hFF);
    checkOutput("cmd_bright_255", 32'(brightness), 32'd255);
    repeat (SLOT) @(negedge clk);
    cnt_on = 0;
    repeat (SCAN) begin @(negedge clk); if (row == 8'h01 && col == 8'h81) cnt_on++; end
    checkOutput("full_on_cycles", 32'(cnt_on), 32'd255);

    // Key saturation and priority
    sendByte(8'hB1); sendByte(8'hFA);
    checkOutput("cmd_bright_250", 32'(brightness), 32'd250);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("key_up_sat", 32'(brightness), 32'd255);
    sendByte(8'hB1); sendByte(8'h0A);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("key_down_sat", 32'(brightness), 32'd0);
    sendByte(8'hB1); sendByte(8'h80);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("key_both", 32'(brightness), 32'd128);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("key_up_step", 32'(brightness), 32'd144);
    sendByte(8'hB1);
    applyStimulus(8'h40, 1'b1, 1'b0, 1'b1);
    checkOutput("cmd_over_key", 32'(brightness), 32'd64);

    // Timeout abort
    sendByte(8'hA5); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    got = 0;
    for (int i = 1; i <= 2 * TO && got == 0; i++) begin
      @(negedge clk);
      if (proto_err) got = i;
    end
    checkOutput("timeout_cycles", 32'(got), 32'(TO));
    checkOutput("timeout_busy", 32'(busy), 32'h0);

`ifdef DOUBLE_BUFFER_EN
    // Frame completing during row 3 must not show until the next row 0
    for (int i = 0; i < SCAN && (t % SCAN) != 3 * SLOT + 2; i++) @(negedge clk);
    sendByte(8'hA5);
    foreach (f2[i]) sendByte(f2[i]);
    checkOutput("db_row3_row", 32'(row), 32'h08);
    checkOutput("db_row3_old", 32'(col), 32'h18);
    got = 0;
    for (int i = 0; i < 2 * SCAN && got == 0; i++) begin
      @(negedge clk);
      if (row == 8'h01) got = 1;
    end
    checkOutput("db_row0_seen", 32'(got), 32'h1);
    checkOutput("db_row0_new", 32'(col), 32'h01);
`endif

    // Reset in the middle of a frame command
    sendByte(8'hA5); sendByte(8'h11); sendByte(8'h22);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_brightness", 32'(brightness), 32'd128);
    checkOutput("midrst_row", 32'(row), 32'h0);
    checkOutput("midrst_col", 32'(col), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_first_row", 32'(row), 32'h01);
    checkOutput("midrst_cleared_col", 32'(col), 32'h00);
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
